// File: rtl/processor_io_bank.sv
// Multi-channel synchronised I/O bank with per-bit rising-edge interrupts.
// Per-channel DATA_IN / DATA_OUT / EDGE / MASK registers on a single-cycle bus.
module processor_io_bank #(
  parameter  int WIDTH       = 32,
  parameter  int CH_BITS     = 2,
  parameter  int SYNC_STAGES = 2,
  localparam int CHANNELS    = 2**CH_BITS,
  localparam int CW          = CHANNELS*WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CW-1:0]      pin_in,
  output logic [CW-1:0]      pin_out,
  input  logic [CH_BITS+1:0] bus_addr,
  input  logic               bus_wr,
  input  logic               bus_rd,
  input  logic [WIDTH-1:0]   bus_wdata,
  output logic [WIDTH-1:0]   bus_rdata,
  output logic               bus_rvalid,
  output logic               irq
);

  logic [SYNC_STAGES-1:0][CW-1:0] sync_q;
  logic [CW-1:0] prev_q;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] pend_q, pend_d;
  logic [CW-1:0] mask_q, mask_d;
  logic [CW-1:0] sync_v, rise, clr;
  logic [WIDTH-1:0] rdata_q, rd_mux;
  logic rvalid_q, irq_q;
  logic [CH_BITS-1:0] ch;
  logic [1:0] rsel;
  int base;

  assign ch     = bus_addr[CH_BITS+1:2];
  assign rsel   = bus_addr[1:0];
  assign base   = int'(ch) * WIDTH;
  assign sync_v = sync_q[SYNC_STAGES-1];
  assign rise   = sync_v & ~prev_q;

  always_comb begin
    out_d  = out_q;
    mask_d = mask_q;
    clr    = '0;
    rd_mux = '0;
    unique case (1'b1)
      bus_wr && rsel == 2'd1: out_d[base +: WIDTH]  = bus_wdata;
      bus_wr && rsel == 2'd2: clr[base +: WIDTH]    = bus_wdata;
      bus_wr && rsel == 2'd3: mask_d[base +: WIDTH] = bus_wdata;
      default: ;
    endcase
    unique case (rsel)
      2'd0: rd_mux = sync_v[base +: WIDTH];
      2'd1: rd_mux = out_q[base +: WIDTH];
      2'd2: rd_mux = pend_q[base +: WIDTH];
      2'd3: rd_mux = mask_q[base +: WIDTH];
    endcase
    // a new rise wins over a same-cycle W1C clear
    pend_d = (pend_q & ~clr) | rise;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      prev_q   <= '0;
      out_q    <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pin_in};
      prev_q   <= sync_v;
      out_q    <= out_d;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      rvalid_q <= bus_rd;
      irq_q    <= |(pend_q & mask_q);
      if (bus_rd) rdata_q <= rd_mux;
    end
  end

  assign pin_out    = out_q;
  assign bus_rdata  = rdata_q;
  assign bus_rvalid = rvalid_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_processor_io_bank.sv
// Randomised scoreboard bench for processor_io_bank.
// Reference model tracks pin history and per-channel register arrays.
module tb_processor_io_bank;

  localparam int W  = 32;
  localparam int CB = 2;
  localparam int S  = 2;
  localparam int CH = 4;

  logic           clk;
  logic           rst;
  logic [CH*W-1:0] pin_in;
  logic [CH*W-1:0] pin_out;
  logic [CB+1:0]  bus_addr;
  logic           bus_wr;
  logic           bus_rd;
  logic [W-1:0]   bus_wdata;
  logic [W-1:0]   bus_rdata;
  logic           bus_rvalid;
  logic           irq;

  processor_io_bank #(
    .WIDTH(W), .CH_BITS(CB), .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .pin_in    (pin_in),
    .pin_out   (pin_out),
    .bus_addr  (bus_addr),
    .bus_wr    (bus_wr),
    .bus_rd    (bus_rd),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_rvalid(bus_rvalid),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model
  logic [W-1:0]    m_out  [CH];
  logic [W-1:0]    m_mask [CH];
  logic [W-1:0]    m_pend [CH];
  logic [CH*W-1:0] hist   [S+1];
  logic [W-1:0]    exp_q  [$];
  logic            exp_rvalid;
  logic            exp_irq;

  always @(posedge clk or posedge rst) begin
    logic [CH*W-1:0] sv, pv, rs;
    logic [W-1:0] v, clr;
    int c, r;
    if (rst) begin
      for (int i = 0; i < CH; i++) begin
        m_out[i] = '0; m_mask[i] = '0; m_pend[i] = '0;
      end
      for (int i = 0; i <= S; i++) hist[i] = '0;
      exp_q.delete();
      exp_rvalid = 1'b0;
      exp_irq    = 1'b0;
    end else begin
      sv = hist[S-1];
      pv = hist[S];
      c  = int'(bus_addr[CB+1:2]);
      r  = int'(bus_addr[1:0]);
      exp_rvalid = bus_rd;
      if (bus_rd) begin
        case (r)
          0: v = sv[c*W +: W];
          1: v = m_out[c];
          2: v = m_pend[c];
          default: v = m_mask[c];
        endcase
        exp_q.push_back(v);
      end
      exp_irq = 1'b0;
      for (int i = 0; i < CH; i++)
        if ((m_pend[i] & m_mask[i]) != 0) exp_irq = 1'b1;
      rs = sv & ~pv;
      for (int i = 0; i < CH; i++) begin
        clr = (bus_wr && r == 2 && c == i) ? bus_wdata : '0;
        m_pend[i] = (m_pend[i] & ~clr) | rs[i*W +: W];
      end
      if (bus_wr && r == 1) m_out[c]  = bus_wdata;
      if (bus_wr && r == 3) m_mask[c] = bus_wdata;
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = pin_in;
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      chk("rvalid", {31'd0, bus_rvalid}, {31'd0, exp_rvalid});
      if (exp_rvalid) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL sb_empty: got rvalid, expected queued data");
        end else begin
          e = exp_q.pop_front();
          if (bus_rvalid) chk("rdata", bus_rdata, e);
        end
      end
      chk("irq", {31'd0, irq}, {31'd0, exp_irq});
      for (int i = 0; i < CH; i++)
        chk("pin_out", pin_out[i*W +: W], m_out[i]);
    end
  end

  task automatic op(input logic rd, input logic wr,
                    input int c, input int r, input logic [W-1:0] d);
    bus_rd    = rd;
    bus_wr    = wr;
    bus_addr  = {2'(c), 2'(r)};
    bus_wdata = d;
    @(negedge clk);
  endtask

  task automatic idle();
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pin_in = '0; bus_addr = '0; bus_wr = 1'b0;
    bus_rd = 1'b0; bus_wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset_pin_out", pin_out[31:0], 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'h0);
    rst = 1'b0;
    idle();

    // output write / readback
    op(0, 1, 2, 1, 32'hA5A5_0101);
    chk("dout_pins", pin_out[95:64], 32'hA5A5_0101);
    op(1, 0, 2, 1, 0);
    chk("dout_rd", bus_rdata, 32'hA5A5_0101);
    chk("dout_rv", {31'd0, bus_rvalid}, 32'h1);
    idle();
    chk("dout_rv_drop", {31'd0, bus_rvalid}, 32'h0);

    // input synchroniser latency
    pin_in[31:0] = 32'h0000_0101;
    idle();
    op(1, 0, 0, 0, 0);
    chk("sync_early", bus_rdata, 32'h0);
    op(1, 0, 0, 0, 0);
    chk("sync_late", bus_rdata, 32'h0000_0101);

    // edge interrupt on channel 3 bit 0
    op(0, 1, 3, 3, 32'h1);
    pin_in[96] = 1'b1;
    idle();
    idle();
    idle();
    chk("irq_not_yet", {31'd0, irq}, 32'h0);
    op(1, 0, 3, 2, 0);
    chk("edge_rd", bus_rdata, 32'h1);
    chk("irq_rise", {31'd0, irq}, 32'h1);
    op(0, 1, 3, 2, 32'h1);
    chk("irq_hold", {31'd0, irq}, 32'h1);
    idle();
    chk("irq_fall", {31'd0, irq}, 32'h0);

    // set beats clear on channel 0 bit 1
    op(0, 1, 0, 2, 32'hFFFF_FFFF);
    pin_in[1] = 1'b1;
    repeat (3) idle();
    op(0, 1, 0, 3, 32'h2);
    pin_in[1] = 1'b0;
    repeat (3) idle();
    chk("sbc_irq_pre", {31'd0, irq}, 32'h1);
    pin_in[1] = 1'b1;
    idle();
    idle();
    op(0, 1, 0, 2, 32'h2);
    chk("sbc_irq_a", {31'd0, irq}, 32'h1);
    op(1, 0, 0, 2, 0);
    chk("sbc_edge", bus_rdata, 32'h2);
    chk("sbc_irq_b", {31'd0, irq}, 32'h1);

    // simultaneous read and write
    op(0, 1, 1, 1, 32'h1234);
    op(1, 1, 1, 1, 32'h5678);
    chk("rw_old", bus_rdata, 32'h1234);
    op(1, 0, 1, 1, 0);
    chk("rw_new", bus_rdata, 32'h5678);

    // asynchronous reset mid-cycle
    op(0, 1, 1, 1, 32'hFFFF_0000);
    op(1, 0, 1, 1, 0);
    chk("pre_rst_irq", {31'd0, irq}, 32'h1);
    chk("pre_rst_pins", pin_out[63:32], 32'hFFFF_0000);
    #2 rst = 1'b1;
    #1;
    chk("rst_pins", pin_out[63:32], 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'h0);
    chk("rst_rdata", bus_rdata, 32'h0);
    chk("rst_rvalid", {31'd0, bus_rvalid}, 32'h0);
    bus_rd = 1'b0;
    bus_wr = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle();

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(3, 0) == 0)
        pin_in[$urandom_range(CH*W-1, 0)] ^= 1'b1;
      if ($urandom_range(7, 0) == 0)
        pin_in[$urandom_range(3, 0)*W + $urandom_range(3, 0)] ^= 1'b1;
      if (n == 300) begin
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      op(1'($urandom), 1'($urandom), int'($urandom_range(3, 0)),
         int'($urandom_range(3, 0)),
         ($urandom_range(1, 0) == 1) ? $urandom : (32'h1 << $urandom_range(3, 0)));
    end
    repeat (4) idle();
    chk("sb_drained", exp_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/processor_io_bank.md
# processor_io_bank

Parametrised multi-channel I/O block that sits between the processor core and its external pins. It replaces the single fixed 32-bit in/out pair with CHANNELS independent ports of WIDTH bits each. Every input is synchronised, and rising edges latch per-bit interrupt-pending flags. The core reaches all registers through a simple single-cycle register bus and receives one combined interrupt line.

## Interface
- WIDTH, 32: bits per channel.
- CH_BITS, 2: channel-select bits; CHANNELS = 2**CH_BITS.
- SYNC_STAGES, 2: input synchroniser depth; legal range 2..4.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- pin_in  in  CHANNELS*WIDTH  external inputs; channel c occupies bits [c*WIDTH +: WIDTH]; asynchronous to clk.
- pin_out  out  CHANNELS*WIDTH  output registers, packed the same way as pin_in.
- bus_addr  in  CH_BITS+2  {channel, reg[1:0]}.
- bus_wr  in  1  write strobe; one write per cycle.
- bus_rd  in  1  read strobe.
- bus_wdata  in  WIDTH  write data.
- bus_rdata  out  WIDTH  read data; registered; holds its value until the next read.
- bus_rvalid  out  1  one-cycle pulse marking valid bus_rdata.
- irq  out  1  registered OR of (pending & mask) across all channels.

## Operation
- Per-channel register map (reg field):
  - 0 DATA_IN: read-only; synchronised pin value. Writes are ignored.
  - 1 DATA_OUT: read/write; drives pin_out.
  - 2 EDGE: pending rising-edge flags. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 3 MASK: read/write; interrupt enable per bit.
- Synchroniser: SYNC_STAGES flops per bit. prev is one further flop holding the last synchronised value.
- Edge detect: rise = sync & ~prev. Update rule: pending <= (pending & ~clr) | rise, where clr = bus_wdata when writing EDGE of that channel, otherwise 0.
  - Set beats clear: a bit that rises in the same cycle as its W1C write remains 1.
- irq <= |(pending[c] & mask[c]) over all c.
  - Changing MASK takes effect on irq one cycle after the write edge.
  - No other interrupt state exists; clearing all pending bits drops irq.
- Read: bus_rd at edge N loads bus_rdata with the addressed register's value as it stood before edge N, and bus_rvalid = 1 for the cycle after edge N.
- Simultaneous bus_rd and bus_wr:
  - The write is performed.
  - The read returns the pre-write value.
  - Addresses may differ.
- No bus_rd: bus_rvalid = 0 and bus_rdata holds its value.
- Falling edges are not captured. A pulse shorter than one clk may be missed; this is accepted behaviour.
- Reset (asserted at any time, including mid-transaction):
  - Immediately clears all synchroniser, prev, DATA_OUT, EDGE and MASK flops.
  - Drives bus_rdata = 0, bus_rvalid = 0, irq = 0 and pin_out = 0.
  - An in-flight read or write is discarded.
- After reset release, prev = 0. A pin that is already high therefore generates one pending edge once it propagates; this is intended.

## Timing
- pin_in value sampled at edge N:
  - sync output updates at edge N+SYNC_STAGES-1.
  - The pending bit is set at edge N+SYNC_STAGES.
  - irq rises at edge N+SYNC_STAGES+1 when masked in.
- DATA_OUT write at edge N: pin_out changes at edge N.
- MASK write at edge N: irq reflects the new mask at edge N+1.
- EDGE clear at edge N: the pending bit drops at edge N; irq drops at edge N+1.
- Read: latency 1; a back-to-back bus_rd every cycle gives one result per cycle.
- Throughput: one bus operation per cycle; there are no stall or wait states.

## Test plan
All scenarios use the default parameters.
- Reset: assert rst mid-cycle with DATA_OUT[1] = 32'hFFFF_0000 and irq = 1 -> pin_out, irq, bus_rdata and bus_rvalid all read 0 before the next clk edge.
- Output write/readback: write 32'hA5A5_0101 to addr {2,1} -> pin_out[95:64] = 32'hA5A5_0101 after that edge. A read of {2,1} then returns the same value with bus_rvalid high for exactly one cycle.
- Input sync: drive pin_in[31:0] = 32'h0000_0101 at edge 10 -> a read of {0,0} issued at edge 12 returns 32'h0000_0101 one cycle later. A read issued at edge 11 returns 0.
- Edge interrupt:
  - Setup: MASK {3,3} = 32'h1, then raise pin_in[96] at edge 20.
  - EDGE {3,2} reads 32'h1 after edge 22; irq = 1 after edge 23.
  - Writing 32'h1 to {3,2} clears the flag; irq falls one edge later.
- Set-beats-clear: a W1C write to {0,2} of 32'h2 coincides with a new rise on bit 1 -> EDGE stays 32'h2 and irq stays asserted when masked.
- Simultaneous read/write: bus_rd and bus_wr to {1,1} in the same cycle with old value 32'h1234 and new value 32'h5678 -> bus_rdata = 32'h1234, and the next read returns 32'h5678.
